// File: rtl/u_cla12_serial_add.sv
// rtl/u_cla12_serial_add.sv - serial multi-word adder, one 12-bit carry-lookahead slice per cycle
module u_cla12_serial_add #(
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [12*NUM_WORDS-1:0] a,
  input  logic [12*NUM_WORDS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [12*NUM_WORDS:0]   out_sum,
  output logic                    busy
);

  localparam int W  = 12 * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q, res_q, res_next;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [11:0]   a_sl, b_sl;
  logic [12:0]   sum;

  // Each carry is a flat AND-OR of generate/propagate terms, so no carry ripples bit to bit.
  function automatic logic [12:0] cla12(input logic [11:0] x, input logic [11:0] y,
                                        input logic ci);
    logic [11:0] g, p;
    logic [12:0] c;
    logic        pp;
    g = x & y;
    p = x ^ y;
    c = 13'b0;
    c[0] = ci;
    for (int i = 0; i < 12; i++) begin
      pp = 1'b1;
      c[i+1] = 1'b0;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return {c[12], p ^ c[11:0]};
  endfunction

  always_comb begin
    a_sl = 12'b0;
    b_sl = 12'b0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_q[12*k +: 12];
        b_sl = b_q[12*k +: 12];
      end
    end
  end

  assign sum = cla12(a_sl, b_sl, carry);

  always_comb begin
    res_next = res_q;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (cnt == CW'(k)) res_next[12*k +: 12] = sum[11:0];
    end
  end

  // Slices accumulate in res_q; out_sum only moves on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      out_sum   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            cnt      <= '0;
            carry    <= 1'b0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res_q <= res_next;
          carry <= sum[12];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_sum   <= {sum[12], res_next};
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
